// File: rtl/vend_pkg.sv
// Shared types and constants for the vending purchase controller:
// item prices, FSM state encoding and the item-to-price lookup.
package vend_pkg;

  localparam logic [7:0] PRICE_APPLE  = 8'd75;
  localparam logic [7:0] PRICE_BANANA = 8'd20;
  localparam logic [7:0] PRICE_CARROT = 8'd30;
  localparam logic [7:0] PRICE_DATE   = 8'd40;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_DEBIT    = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_DISPENSE = 3'd4,
    ST_DENY     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ITEM_APPLE  = 2'd0,
    ITEM_BANANA = 2'd1,
    ITEM_CARROT = 2'd2,
    ITEM_DATE   = 2'd3
  } item_t;

  function automatic logic [7:0] item_price(input item_t item);
    logic [7:0] price;
    case (item)
      ITEM_APPLE:  price = PRICE_APPLE;
      ITEM_BANANA: price = PRICE_BANANA;
      ITEM_CARROT: price = PRICE_CARROT;
      ITEM_DATE:   price = PRICE_DATE;
      default:     price = PRICE_APPLE;
    endcase
    return price;
  endfunction

endpackage

// File: rtl/vend_controller_rise_detect.sv
// Four-lane rising-edge detector. History resets high so a level already
// asserted when reset releases is not seen as a new edge.
module rise_detect (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_level,
  output logic [3:0] o_rise
);

  logic [3:0] r_hist;

  // previous-cycle level of each input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= 4'b1111;
    end else begin
      r_hist <= i_level;
    end
  end

  assign o_rise = i_level & ~r_hist;

endmodule

// File: rtl/vend_controller.sv
// Purchase controller: latches one button edge in IDLE, checks price against
// credit, issues one debit pulse to the piggy bank, then a timed chute strobe.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned DISPENSE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] credit,
  input  logic       sel_apple,
  input  logic       sel_banana,
  input  logic       sel_carrot,
  input  logic       sel_date,
  output logic       apple,
  output logic       banana,
  output logic       carrot,
  output logic       date,
  output logic [3:0] dispense,
  output logic       deny,
  output logic       busy
);

  localparam logic [3:0] CNT_LOAD = 4'(DISPENSE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;
  item_t      r_item;
  item_t      w_next_item;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;
  logic [3:0] w_rise;

  rise_detect u_rise (
    .clk     (clk),
    .reset   (reset),
    .i_level ({sel_apple, sel_banana, sel_carrot, sel_date}),
    .o_rise  (w_rise)
  );

  // state, latched item and dispense counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_item  <= ITEM_APPLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_item  <= w_next_item;
      r_cnt   <= w_next_cnt;
    end
  end

  // next-state logic; edges outside IDLE are simply dropped
  always_comb begin
    w_next_state = r_state;
    w_next_item  = r_item;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_rise != 4'b0000) begin
          w_next_state = ST_CHECK;
          if (w_rise[3]) begin
            w_next_item = ITEM_APPLE;
          end else if (w_rise[2]) begin
            w_next_item = ITEM_BANANA;
          end else if (w_rise[1]) begin
            w_next_item = ITEM_CARROT;
          end else begin
            w_next_item = ITEM_DATE;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (credit >= item_price(r_item)) begin
          w_next_state = ST_DEBIT;
        end else begin
          w_next_state = ST_DENY;
        end
      end
      ST_DEBIT:  w_next_state = ST_SETTLE;
      ST_SETTLE: begin
        w_next_state = ST_DISPENSE;
        w_next_cnt   = CNT_LOAD;
      end
      ST_DISPENSE: begin
        if (r_cnt == 4'd0) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      ST_DENY:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Moore output decode from registered state and item
  always_comb begin
    apple    = 1'b0;
    banana   = 1'b0;
    carrot   = 1'b0;
    date     = 1'b0;
    dispense = 4'b0000;
    deny     = 1'b0;
    busy     = (r_state != ST_IDLE);
    case (r_state)
      ST_DEBIT: begin
        case (r_item)
          ITEM_APPLE:  apple  = 1'b1;
          ITEM_BANANA: banana = 1'b1;
          ITEM_CARROT: carrot = 1'b1;
          ITEM_DATE:   date   = 1'b1;
          default:     apple  = 1'b0;
        endcase
      end
      ST_DISPENSE: dispense = 4'b1000 >> r_item;
      ST_DENY:     deny     = 1'b1;
      default:     deny     = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: each request pushes its expected
// per-cycle output vectors, which are popped and compared on falling edges.
module tb_vend_controller;

  localparam int DISP = 4;

  logic       clk;
  logic       reset;
  logic [7:0] credit;
  logic       sel_apple, sel_banana, sel_carrot, sel_date;
  logic       apple, banana, carrot, date;
  logic [3:0] dispense;
  logic       deny, busy;
  logic [9:0] w_obs;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  vend_controller #(.DISPENSE_CYCLES(DISP)) dut (
    .clk        (clk),
    .reset      (reset),
    .credit     (credit),
    .sel_apple  (sel_apple),
    .sel_banana (sel_banana),
    .sel_carrot (sel_carrot),
    .sel_date   (sel_date),
    .apple      (apple),
    .banana     (banana),
    .carrot     (carrot),
    .date       (date),
    .dispense   (dispense),
    .deny       (deny),
    .busy       (busy)
  );

  // {debit apple..date, dispense[3:0], deny, busy}
  assign w_obs = {apple, banana, carrot, date, dispense, deny, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic clear_sel();
    sel_apple = 1'b0; sel_banana = 1'b0; sel_carrot = 1'b0; sel_date = 1'b0;
  endtask

  task automatic press(input int item);
    case (item)
      0: sel_apple  = 1'b1;
      1: sel_banana = 1'b1;
      2: sel_carrot = 1'b1;
      default: sel_date = 1'b1;
    endcase
  endtask

  // Expected outputs for the cycles after the edge that samples a press.
  task automatic push_purchase(input int item, input int cr);
    int price;
    logic [9:0] v;
    price = (item == 0) ? 75 : (item == 1) ? 20 : (item == 2) ? 30 : 40;
    exp_q.push_back(10'b00_0000_0001);
    if (cr >= price) begin
      v = 10'b00_0000_0001;
      v[9-item] = 1'b1;
      exp_q.push_back(v);
      exp_q.push_back(10'b00_0000_0001);
      for (int k = 0; k < DISP; k++) begin
        v = 10'b00_0000_0001;
        v[5-item] = 1'b1;
        exp_q.push_back(v);
      end
    end else begin
      exp_q.push_back(10'b00_0000_0011);
    end
    exp_q.push_back(10'b00_0000_0000);
  endtask

  task automatic test_reset();
    logic [9:0] e;
    reset = 1'b0; credit = 8'd0; clear_sel();
    #1;
    e = 10'd0; checks++;
    if (w_obs !== e) begin failures++; $display("FAIL reset_async obs=%b exp=%b", w_obs, e); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (w_obs !== e) begin failures++; $display("FAIL reset_hold obs=%b exp=%b", w_obs, e); end
    end
    reset = 1'b1;
  endtask

  task automatic test_apple();
    logic [9:0] e;
    int idx = 0;
    @(negedge clk);
    credit = 8'd100; press(0); push_purchase(0, 100);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin failures++; $display("FAIL apple_purchase idx=%0d obs=%b exp=%b", idx, w_obs, e); end
      clear_sel();
      if (idx == 1) credit = 8'd0;
      idx++;
    end
  endtask

  task automatic test_boundaries();
    logic [9:0] e;
    int items[8]   = '{0, 0, 1, 1, 2, 2, 3, 3};
    int credits[8] = '{74, 75, 19, 20, 29, 30, 39, 40};
    for (int t = 0; t < 8; t++) begin
      int idx = 0;
      @(negedge clk);
      credit = 8'(credits[t]); press(items[t]); push_purchase(items[t], credits[t]);
      while (exp_q.size() != 0) begin
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (w_obs !== e) begin
          failures++;
          $display("FAIL price_edge item=%0d credit=%0d idx=%0d obs=%b exp=%b", items[t], credits[t], idx, w_obs, e);
        end
        clear_sel();
        idx++;
      end
    end
  endtask

  task automatic test_priority();
    logic [9:0] e;
    int idx = 0;
    @(negedge clk);
    credit = 8'd255; press(0); press(1); push_purchase(0, 255);
    for (int k = 0; k < 3; k++) exp_q.push_back(10'd0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin failures++; $display("FAIL priority_ignore idx=%0d obs=%b exp=%b", idx, w_obs, e); end
      if (idx == 4) press(1); else clear_sel();
      idx++;
    end
  endtask

  task automatic test_held_reset();
    logic [9:0] e;
    int idx = 0;
    @(negedge clk);
    credit = 8'd100; press(0); reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(10'd0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin failures++; $display("FAIL held_through_reset idx=%0d obs=%b exp=%b", idx, w_obs, e); end
      idx++;
    end
    clear_sel();
    @(negedge clk);
    press(0); push_purchase(0, 100);
    idx = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin failures++; $display("FAIL repress_purchase idx=%0d obs=%b exp=%b", idx, w_obs, e); end
      clear_sel();
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    int idx = 0;
    @(negedge clk);
    credit = 8'd100; press(2); push_purchase(2, 100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin failures++; $display("FAIL pre_reset idx=%0d obs=%b exp=%b", k, w_obs, e); end
      clear_sel();
    end
    exp_q.delete();
    #2 reset = 1'b0;
    #1;
    e = 10'd0; checks++;
    if (w_obs !== e) begin failures++; $display("FAIL reset_mid_dispense obs=%b exp=%b", w_obs, e); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    credit = 8'd50; press(1); push_purchase(1, 50);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin failures++; $display("FAIL post_reset_purchase idx=%0d obs=%b exp=%b", idx, w_obs, e); end
      clear_sel();
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    int idx = 0;
    @(negedge clk);
    credit = 8'd10; press(1); push_purchase(1, 10);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin failures++; $display("FAIL back_to_back idx=%0d obs=%b exp=%b", idx, w_obs, e); end
      if (idx == 2) begin
        clear_sel(); press(3); credit = 8'd255; push_purchase(3, 255);
      end else begin
        clear_sel();
      end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_apple();
    test_boundaries();
    test_priority();
    test_held_reset();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Purchase controller that sits directly upstream of the piggy bank's debit inputs and downstream of its credit output. Takes raw customer selection buttons, checks the selected item's price against the current 8-bit credit, issues exactly one single-cycle debit pulse (apple/banana/carrot/date) to the piggy bank when affordable, then drives a timed dispense strobe to the item chute. Insufficient credit produces a deny pulse and no debit.

## Interface
- DISPENSE_CYCLES, 4, cycles the dispense output is held high (legal range 1–15)
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- credit  in  8  current credit in cents from the piggy bank (0–255)
- sel_apple, sel_banana, sel_carrot, sel_date  in  1 each  button levels, already synchronous to clk
- apple, banana, carrot, date  out  1 each  single-cycle debit pulses to the piggy bank
- dispense  out  4  one-hot chute strobe, bit 3 = apple, 2 = banana, 1 = carrot, 0 = date
- deny  out  1  single-cycle pulse: selection refused for insufficient credit
- busy  out  1  high in every state except IDLE

## Operation
- Prices in cents: apple 75, banana 20, carrot 30, date 40.
- Rising-edge detection on each sel_* input. History registers reset to 1, so a button held through reset release does not trigger.
- Request acceptance happens only in IDLE. Edges arriving in any other state are discarded, not queued.
- Multiple simultaneous edges: priority apple > banana > carrot > date. Only the winner is latched; the others are dropped.
- FSM states: IDLE, CHECK, DEBIT, SETTLE, DISPENSE, DENY.
  - IDLE: an accepted edge latches the item, then go to CHECK.
  - CHECK: if credit >= price (unsigned 8-bit compare, equality accepted), go to DEBIT; otherwise go to DENY.
  - DEBIT: assert the item's debit output for this cycle only, then go to SETTLE.
  - SETTLE: one cycle for the piggy bank credit to update, then go to DISPENSE and load the counter with DISPENSE_CYCLES-1.
  - DISPENSE: dispense[item] high; decrement the counter; at 0, go to IDLE.
  - DENY: deny high for this cycle only, then go to IDLE.
- Credit is sampled only in CHECK. Credit changes in other states are ignored.
- Exactly one debit pulse per accepted request. Never more than one debit output high at once.
- All outputs are Moore-decoded from registered state and item. No combinational path from inputs to outputs.
- Reset values: state IDLE, all debit outputs 0, dispense 0, deny 0, busy 0, counter 0, latched item cleared.

## Timing
- Edge sampled at clock edge n (sel high, history low):
  - CHECK during cycle n+1.
  - Debit pulse during cycle n+2.
  - SETTLE during cycle n+3.
  - dispense high during cycles n+4 … n+3+DISPENSE_CYCLES.
  - IDLE from n+4+DISPENSE_CYCLES.
- Deny path: deny high in cycle n+2, IDLE in n+3.
- Minimum spacing between accepted requests: 4+DISPENSE_CYCLES cycles (success) or 3 cycles (deny).
- Reset asserted mid-operation (any state) clears all outputs asynchronously. A debit pulse cut short by reset is not reissued.

## Structure
- Shared package vend_pkg:
  - price constants PRICE_APPLE/BANANA/CARROT/DATE (8-bit)
  - state enum
  - 2-bit item encoding and the item-to-price function
- One sub-module: rise_detect, a 4-bit registered rising-edge detector with reset value 1 on history bits.
- Counter width 4 bits.

## Test plan
- credit=100, pulse sel_apple: apple high exactly one cycle at n+2; dispense=4'b1000 for 4 cycles from n+4; busy low at n+8.
- credit=29, pulse sel_carrot: deny one cycle at n+2; no debit output; dispense stays 0.
- credit=40, pulse sel_date (equality): date debit pulse issued; dispense=4'b0001.
- credit=255, sel_banana and sel_apple rise same cycle: only apple debit. Then a banana edge during DISPENSE: ignored, no second debit.
- sel_apple held high across reset release: no request. Release then re-press: normal purchase.
- Reset asserted during DISPENSE: dispense and busy drop to 0 immediately. After release the FSM is in IDLE and the next request gets standard latency.
